// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, register
// map and STATUS field positions.
`timescale 1ns/1ps
package irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

  localparam logic [1:0] REG_MASK = 2'd0;
  localparam logic [1:0] REG_EDGE = 2'd1;
  localparam logic [1:0] REG_PEND = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  localparam int STAT_BUSY_BIT  = 31;
  localparam int STAT_STATE_LSB = 8;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set index wins.
`timescale 1ns/1ps
module irq_prio_enc #(
  parameter int N_SRC = 8,
  parameter int IDW   = 3
) (
  input  logic [N_SRC-1:0] req,
  output logic             any,
  output logic [IDW-1:0]   idx
);

  // Scan from the top down so the lowest requesting index is the last written.
  always_comb begin
    any = |req;
    idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) idx = IDW'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronises N_SRC external lines, tracks pending
// requests (edge or level per source), selects the lowest-index eligible
// source and runs a single-level request/service handshake with CP0.
//
// Handshake: ir_out is high exactly while the FSM is in ASSERT. An ir_ack
// pulse is honoured only in ASSERT and moves the FSM to SERVICE (clearing the
// edge-pending bit of irq_id); an eret pulse is honoured only in SERVICE and
// returns it to IDLE. Pulses arriving in any other state are dropped.
// STATUS (address 3) exposes the FSM state for software and debug.
`timescale 1ns/1ps
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int N_SRC = 8,
  parameter int IDW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_src,
  output logic             ir_out,
  output logic [IDW-1:0]   irq_id,
  input  logic             ir_ack,
  input  logic             eret,
  input  logic             reg_wen,
  input  logic             reg_ren,
  input  logic [1:0]       reg_addr,
  input  logic [31:0]      reg_din,
  output logic [31:0]      reg_dout
);

  logic [N_SRC-1:0] sync1_q, sync2_q, sync2_dly_q;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] edge_q, edge_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  irq_state_e       state_q, state_d;
  logic [IDW-1:0]   irq_id_q, irq_id_d;
  logic             ir_out_q, ir_out_d;
  logic [31:0]      reg_dout_q, reg_dout_d;

  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] w1c;
  logic [N_SRC-1:0] ack_clr;
  logic             cur_eligible;
  logic             win_any;
  logic [IDW-1:0]   win_idx;
  logic [31:0]      rd_val;
  logic             unused_din;

  assign unused_din = ^reg_din;

  assign eligible = pend_q & mask_q;

  irq_prio_enc #(.N_SRC(N_SRC), .IDW(IDW)) u_prio (
    .req (eligible),
    .any (win_any),
    .idx (win_idx)
  );

  // Pending update: edge bits set on rise (set beats clear), level bits track the line.
  always_comb begin
    rise         = sync2_q & ~sync2_dly_q;
    w1c          = (reg_wen && reg_addr == REG_PEND) ? reg_din[N_SRC-1:0] : '0;
    ack_clr      = '0;
    cur_eligible = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (IDW'(i) == irq_id_q) begin
        ack_clr[i]   = (state_q == ST_ASSERT) && ir_ack;
        cur_eligible = eligible[i];
      end
    end
    pend_d = (edge_q & ((pend_q & ~(w1c | ack_clr)) | rise)) | (~edge_q & sync2_q);
  end

  // Request/service FSM; the id is latched on entry to ASSERT and frozen after.
  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_any) begin
          state_d  = ST_ASSERT;
          irq_id_d = win_idx;
        end
      end
      ST_ASSERT: begin
        if (ir_ack)             state_d = ST_SERVICE;
        else if (!cur_eligible) state_d = ST_IDLE;
      end
      ST_SERVICE: begin
        if (eret) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    ir_out_d = (state_d == ST_ASSERT);
  end

  // Register writes and registered read port (reads see pre-write values).
  always_comb begin
    mask_d = mask_q;
    edge_d = edge_q;
    if (reg_wen && reg_addr == REG_MASK) mask_d = reg_din[N_SRC-1:0];
    if (reg_wen && reg_addr == REG_EDGE) edge_d = reg_din[N_SRC-1:0];
    rd_val = '0;
    unique case (reg_addr)
      REG_MASK: rd_val = 32'(mask_q);
      REG_EDGE: rd_val = 32'(edge_q);
      REG_PEND: rd_val = 32'(pend_q);
      default: begin
        rd_val[STAT_BUSY_BIT]          = (state_q != ST_IDLE);
        rd_val[STAT_STATE_LSB +: 2]    = state_q;
        rd_val[IDW-1:0]                = irq_id_q;
      end
    endcase
    reg_dout_d = reg_ren ? rd_val : reg_dout_q;
  end

  // State registers, including the two-stage synchroniser and its edge tap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      sync2_dly_q <= '0;
      mask_q      <= '0;
      edge_q      <= '0;
      pend_q      <= '0;
      state_q     <= ST_IDLE;
      irq_id_q    <= '0;
      ir_out_q    <= 1'b0;
      reg_dout_q  <= '0;
    end else begin
      sync1_q     <= irq_src;
      sync2_q     <= sync1_q;
      sync2_dly_q <= sync2_q;
      mask_q      <= mask_d;
      edge_q      <= edge_d;
      pend_q      <= pend_d;
      state_q     <= state_d;
      irq_id_q    <= irq_id_d;
      ir_out_q    <= ir_out_d;
      reg_dout_q  <= reg_dout_d;
    end
  end

  assign ir_out   = ir_out_q;
  assign irq_id   = irq_id_q;
  assign reg_dout = reg_dout_q;

endmodule
